descramble: RTL and testbench

Serial 100BASE-TX descrambler: the receive-side counterpart of the transmit scrambler, with the same 11-bit LFSR and polynomial x^11 + x^9 + 1. The LFSR self-synchronises by loading keystream inferred from received idle, which is all ones before scrambling. It then tracks lock and falls out of lock when no idle run appears within a timeout. It sits between the NRZI/4B5B receive-side bit recovery and the 5-bit code-group aligner.

---
 rtl/descramble.sv | 113 +++++++++++
 tb/tb_descramble.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/descramble.sv
// Serial 100BASE-TX descrambler (x^11 + x^9 + 1). It self-synchronises on idle,
// which is all ones before scrambling, and drops lock when idle runs stop arriving.
module descramble #(
  parameter int LOCK_IDLES = 29,
  parameter int TIMEOUT    = 90250
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scrambled,
  input  logic scrambled_valid,
  output logic unscrambled,
  output logic unscrambled_valid,
  output logic locked
);

  localparam int MW = $clog2(LOCK_IDLES + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [MW-1:0] LOCK_MAX = MW'(LOCK_IDLES);
  localparam logic [TW-1:0] TIME_MAX = TW'(TIMEOUT);

  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} state_e;

  state_e        state_q, state_d;
  logic [10:0]   lfsr_q, lfsr_d;
  logic [MW-1:0] match_q, match_d, match_inc;
  logic [TW-1:0] timer_q, timer_d, timer_inc;
  logic          unscr_q, unscr_d;
  logic          uvalid_q, uvalid_d;
  logic          locked_q, locked_d;
  logic          ks, descr;

  // Handshake: scrambled_valid=1 marks a bit to consume; there is no backpressure.
  // unscrambled_valid=1 marks unscrambled as new, exactly one clock later.
  assign ks        = lfsr_q[8] ^ lfsr_q[10];
  assign descr     = scrambled ^ ks;
  assign match_inc = match_q + MW'(1);
  assign timer_inc = timer_q + TW'(1);

  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    match_d  = match_q;
    timer_d  = timer_q;
    unscr_d  = unscr_q;
    uvalid_d = scrambled_valid;
    locked_d = locked_q;
    if (scrambled_valid) begin
      unscr_d = descr;
      case (state_q)
        UNLOCKED: begin
          // Assume idle: the inverted input bit is the transmitter's keystream.
          lfsr_d = {lfsr_q[9:0], ~scrambled};
          if (ks == ~scrambled) begin
            if (match_inc == LOCK_MAX) begin
              state_d  = LOCKED;
              locked_d = 1'b1;
              timer_d  = '0;
              match_d  = '0;
            end else begin
              match_d = match_inc;
            end
          end else begin
            match_d = '0;
          end
        end
        LOCKED: begin
          lfsr_d = {lfsr_q[9:0], ks};
          if (descr && (match_inc == LOCK_MAX)) begin
            // A completed idle run beats a timer expiring on the same bit.
            match_d = '0;
            timer_d = '0;
          end else begin
            match_d = descr ? match_inc : '0;
            if (timer_inc == TIME_MAX) begin
              state_d  = UNLOCKED;
              locked_d = 1'b0;
              match_d  = '0;
              timer_d  = '0;
            end else begin
              timer_d = timer_inc;
            end
          end
        end
        default: state_d = UNLOCKED;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= UNLOCKED;
      lfsr_q   <= '0;
      match_q  <= '0;
      timer_q  <= '0;
      unscr_q  <= 1'b0;
      uvalid_q <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      match_q  <= match_d;
      timer_q  <= timer_d;
      unscr_q  <= unscr_d;
      uvalid_q <= uvalid_d;
      locked_q <= locked_d;
    end
  end

  assign unscrambled       = unscr_q;
  assign unscrambled_valid = uvalid_q;
  assign locked            = locked_q;

endmodule

// File: tb/tb_descramble.sv
// Bench for descramble: a table-driven acquisition stream plus directed sequences
// for gapped valid, corrupted idle, timeout and asynchronous reset.
module tb_descramble;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic scrambled = 1'b0;
  logic scrambled_valid = 1'b0;
  logic u_a, uv_a, lk_a;
  logic u_b, uv_b, lk_b;
  logic [10:0] scr_s;
  int total = 0;
  int bad = 0;

  typedef struct {
    logic plain;
    logic exp_out;
    logic exp_lock;
  } vec_t;
  vec_t tbl[56];

  // Expected output of idle bits 1..11 while the LFSR fills, for seed 11'h5a3.
  logic [10:0] fill_exp = 11'b00001011001;
  logic [15:0] data_bits = {8'hD3, 8'h55};

  always #5 clk = ~clk;

  descramble dut_a (
    .clk(clk), .rst_n(rst_n), .scrambled(scrambled), .scrambled_valid(scrambled_valid),
    .unscrambled(u_a), .unscrambled_valid(uv_a), .locked(lk_a)
  );

  descramble #(.LOCK_IDLES(29), .TIMEOUT(1000)) dut_b (
    .clk(clk), .rst_n(rst_n), .scrambled(scrambled), .scrambled_valid(scrambled_valid),
    .unscrambled(u_b), .unscrambled_valid(uv_b), .locked(lk_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic scramble(input logic plain, output logic s);
    logic k;
    k = scr_s[8] ^ scr_s[10];
    scr_s = {scr_s[9:0], k};
    s = plain ^ k;
  endtask

  task automatic send(input logic s);
    scrambled = s;
    scrambled_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic gap_cycle();
    logic hold_u, hold_l;
    hold_u = u_a;
    hold_l = lk_a;
    scrambled_valid = 1'b0;
    scrambled = 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
    chk("gap_uv", uv_a, 0);
    chk("gap_hold_out", u_a, hold_u);
    chk("gap_hold_lock", lk_a, hold_l);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      scrambled = 1'($urandom_range(0, 1));
      scrambled_valid = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    chk("rst_out_a", u_a, 0);
    chk("rst_uv_a", uv_a, 0);
    chk("rst_lock_a", lk_a, 0);
    chk("rst_out_b", u_b, 0);
    chk("rst_uv_b", uv_b, 0);
    chk("rst_lock_b", lk_b, 0);
    scrambled_valid = 1'b0;
    rst_n = 1'b1;
    scr_s = 11'h5a3;
    @(posedge clk);
    #1;
  endtask

  task automatic acquire_b(input string tag);
    logic s;
    do_reset();
    for (int n = 1; n <= 40; n++) begin
      scramble(1'b1, s);
      send(s);
    end
    chk({tag, "_lock"}, lk_b, 1);
  endtask

  // run_end=0 means no idle run; chk_lo=0 means no drop is expected in range.
  task automatic timeout_case(input string tag, input int run_end, input int last,
                              input int chk_hi1, input int chk_hi2, input int chk_lo);
    logic s, p;
    acquire_b(tag);
    for (int i = 1; i <= last; i++) begin
      if (run_end > 0 && i > run_end - 29 && i <= run_end) p = 1'b1;
      else p = (i % 2 == 0);
      scramble(p, s);
      send(s);
      chk($sformatf("%s_data[%0d]", tag, i), u_b, p);
      if (i == chk_hi1 || i == chk_hi2) chk($sformatf("%s_hold[%0d]", tag, i), lk_b, 1);
      if (i == chk_lo) chk($sformatf("%s_drop[%0d]", tag, i), lk_b, 0);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic s, eo;
    for (int i = 0; i < 56; i++) begin
      if (i < 40) begin
        tbl[i].plain    = 1'b1;
        tbl[i].exp_out  = (i < 11) ? fill_exp[i] : 1'b1;
        tbl[i].exp_lock = (i >= 39);
      end else begin
        tbl[i].plain    = data_bits[i-40];
        tbl[i].exp_out  = data_bits[i-40];
        tbl[i].exp_lock = 1'b1;
      end
    end

    // Continuous acquisition
    do_reset();
    for (int i = 0; i < 56; i++) begin
      scramble(tbl[i].plain, s);
      send(s);
      chk($sformatf("acq_uv[%0d]", i + 1), uv_a, 1);
      chk($sformatf("acq_out[%0d]", i + 1), u_a, tbl[i].exp_out);
      chk($sformatf("acq_lock[%0d]", i + 1), lk_a, tbl[i].exp_lock);
    end

    // Same stream with valid toggling 1/0
    do_reset();
    for (int i = 0; i < 56; i++) begin
      scramble(tbl[i].plain, s);
      send(s);
      chk($sformatf("gap_out[%0d]", i + 1), u_a, tbl[i].exp_out);
      chk($sformatf("gap_lock[%0d]", i + 1), lk_a, tbl[i].exp_lock);
      gap_cycle();
    end

    // Corrupted idle bit 20 poisons predictions at bits 29 and 31
    do_reset();
    for (int n = 1; n <= 70; n++) begin
      scramble(1'b1, s);
      if (n == 20) s = ~s;
      send(s);
      if (n <= 11) eo = fill_exp[n-1];
      else eo = !(n == 20 || n == 29 || n == 31);
      chk($sformatf("mis_out[%0d]", n), u_a, eo);
      chk($sformatf("mis_lock[%0d]", n), lk_a, (n >= 60));
    end

    // Asynchronous reset pulse while locked
    chk("ar_pre_lock", lk_a, 1);
    chk("ar_pre_uv", uv_a, 1);
    #2;
    rst_n = 1'b0;
    scrambled_valid = 1'b0;
    #1;
    chk("ar_lock_drop", lk_a, 0);
    chk("ar_uv_drop", uv_a, 0);
    chk("ar_lock_drop_b", lk_b, 0);
    #4;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    scr_s = 11'h5a3;
    for (int n = 1; n <= 40; n++) begin
      scramble(1'b1, s);
      send(s);
      if (n == 39) chk("ar_relock_early", lk_a, 0);
      if (n == 40) chk("ar_relock", lk_a, 1);
    end

    // Timeout behaviour on the TIMEOUT=1000 instance
    timeout_case("to_none", 0, 1000, 999, 999, 1000);
    timeout_case("to_run900", 900, 1900, 1000, 1899, 1900);
    timeout_case("to_run1000", 1000, 1001, 1000, 1001, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
